// File: rtl/sc_reg_shifter.sv
// sc_reg_shifter: operand register shifted one bit per clock under Start/Busy/Done; Done pulses after edge k+N+1.
// No backpressure: Load/Start act only in IDLE. Define SC_REGSHIFTER_ROTATE_EN to add the rotate input.
module sc_reg_shifter #(
    parameter int                       DATAWIDTH_BUS      = 32,
    parameter logic [DATAWIDTH_BUS-1:0] DATA_REGSHIFT_INIT = '0,
    parameter int                       SHAMT_WIDTH        = 5
) (
    input  logic                     SC_RegSHIFTER_CLOCK_50,
    input  logic                     SC_RegSHIFTER_RESET_InHigh,
    input  logic [DATAWIDTH_BUS-1:0] SC_RegSHIFTER_DataBUS_In,
    input  logic                     SC_RegSHIFTER_Load_InHigh,
    input  logic                     SC_RegSHIFTER_Start_InHigh,
    input  logic                     SC_RegSHIFTER_Dir_InHigh,
    input  logic                     SC_RegSHIFTER_Arith_InHigh,
    input  logic [SHAMT_WIDTH-1:0]   SC_RegSHIFTER_Shamt_In,
`ifdef SC_REGSHIFTER_ROTATE_EN
    input  logic                     SC_RegSHIFTER_Rotate_InHigh,
`endif
    output logic [DATAWIDTH_BUS-1:0] SC_RegSHIFTER_DataBUS_Out,
    output logic                     SC_RegSHIFTER_Busy_Out,
    output logic                     SC_RegSHIFTER_Done_Out
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } stateType;

    stateType                 stateReg, stateNext;
    logic [DATAWIDTH_BUS-1:0] dataReg, dataNext, shiftedData;
    logic [SHAMT_WIDTH-1:0]   countReg, countNext;
    logic                     dirReg, dirNext;
    logic                     arithReg, arithNext;
    logic                     doneReg;
    logic                     fillLeft, fillRight;
`ifdef SC_REGSHIFTER_ROTATE_EN
    logic                     rotReg, rotNext;
`endif

    // Bit entering the vacated end; rotate takes precedence over sign fill.
    always_comb begin
`ifdef SC_REGSHIFTER_ROTATE_EN
        fillLeft  = rotReg ? dataReg[DATAWIDTH_BUS-1] : 1'b0;
        fillRight = rotReg ? dataReg[0] : (arithReg & dataReg[DATAWIDTH_BUS-1]);
`else
        fillLeft  = 1'b0;
        fillRight = arithReg & dataReg[DATAWIDTH_BUS-1];
`endif
        if (dirReg) begin
            shiftedData = {fillRight, dataReg[DATAWIDTH_BUS-1:1]};
        end else begin
            shiftedData = {dataReg[DATAWIDTH_BUS-2:0], fillLeft};
        end
    end

    always_comb begin
        stateNext = stateReg;
        dataNext  = dataReg;
        countNext = countReg;
        dirNext   = dirReg;
        arithNext = arithReg;
`ifdef SC_REGSHIFTER_ROTATE_EN
        rotNext   = rotReg;
`endif
        case (stateReg)
            StIdle: begin
                if (SC_RegSHIFTER_Load_InHigh) begin
                    dataNext = SC_RegSHIFTER_DataBUS_In;
                end else if (SC_RegSHIFTER_Start_InHigh) begin
                    if (SC_RegSHIFTER_Shamt_In != '0) begin
                        dirNext   = SC_RegSHIFTER_Dir_InHigh;
                        arithNext = SC_RegSHIFTER_Arith_InHigh;
`ifdef SC_REGSHIFTER_ROTATE_EN
                        rotNext   = SC_RegSHIFTER_Rotate_InHigh;
`endif
                        countNext = SC_RegSHIFTER_Shamt_In;
                        stateNext = StShift;
                    end else begin
                        stateNext = StDone;
                    end
                end
            end
            StShift: begin
                dataNext  = shiftedData;
                countNext = countReg - SHAMT_WIDTH'(1);
                if (countReg == SHAMT_WIDTH'(1)) begin
                    stateNext = StDone;
                end
            end
            StDone: begin
                stateNext = StIdle;
            end
            default: begin
                stateNext = StIdle;
            end
        endcase
    end

    always_ff @(posedge SC_RegSHIFTER_CLOCK_50) begin
        if (SC_RegSHIFTER_RESET_InHigh) begin
            stateReg <= StIdle;
            dataReg  <= DATA_REGSHIFT_INIT;
            countReg <= '0;
            dirReg   <= 1'b0;
            arithReg <= 1'b0;
            doneReg  <= 1'b0;
`ifdef SC_REGSHIFTER_ROTATE_EN
            rotReg   <= 1'b0;
`endif
        end else begin
            stateReg <= stateNext;
            dataReg  <= dataNext;
            countReg <= countNext;
            dirReg   <= dirNext;
            arithReg <= arithNext;
            // Done is registered off the DONE state, giving the k+N+1 completion edge.
            doneReg  <= (stateReg == StDone);
`ifdef SC_REGSHIFTER_ROTATE_EN
            rotReg   <= rotNext;
`endif
        end
    end

    assign SC_RegSHIFTER_DataBUS_Out = dataReg;
    assign SC_RegSHIFTER_Busy_Out    = (stateReg == StShift);
    assign SC_RegSHIFTER_Done_Out    = doneReg;

endmodule

// File: tb/tb_sc_reg_shifter.sv
// Bench for sc_reg_shifter: directed table, hand-written corner sequences and random ops vs. an arithmetic model.
module tb_sc_reg_shifter;

    localparam int W  = 32;
    localparam int SW = 5;

    logic          clk;
    logic          rst;
    logic [W-1:0]  dataIn;
    logic          load;
    logic          start;
    logic          dir;
    logic          arith;
    logic [SW-1:0] shamt;
    logic          rot;
    logic [W-1:0]  dataOut;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    sc_reg_shifter #(
        .DATAWIDTH_BUS      (W),
        .DATA_REGSHIFT_INIT ('0),
        .SHAMT_WIDTH        (SW)
    ) dut (
        .SC_RegSHIFTER_CLOCK_50     (clk),
        .SC_RegSHIFTER_RESET_InHigh (rst),
        .SC_RegSHIFTER_DataBUS_In   (dataIn),
        .SC_RegSHIFTER_Load_InHigh  (load),
        .SC_RegSHIFTER_Start_InHigh (start),
        .SC_RegSHIFTER_Dir_InHigh   (dir),
        .SC_RegSHIFTER_Arith_InHigh (arith),
        .SC_RegSHIFTER_Shamt_In     (shamt),
`ifdef SC_REGSHIFTER_ROTATE_EN
        .SC_RegSHIFTER_Rotate_InHigh(rot),
`endif
        .SC_RegSHIFTER_DataBUS_Out  (dataOut),
        .SC_RegSHIFTER_Busy_Out     (busy),
        .SC_RegSHIFTER_Done_Out     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] loadVal;
        logic         dir;
        logic         arith;
        logic         rot;
        int           shamt;
        logic [W-1:0] expOut;
    } vecType;

    vecType vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: whole-word result of an N-bit shift/rotate.
    function automatic logic [W-1:0] model(input logic [W-1:0] v, input logic d, input logic a,
                                           input logic r, input int n);
        if (n == 0) return v;
        if (r) return d ? ((v >> n) | (v << (W - n))) : ((v << n) | (v >> (W - n)));
        if (!d) return v << n;
        if (a) return $unsigned($signed(v) >>> n);
        return v >> n;
    endfunction

    // Load, start, then watch Busy/Done while driving junk that the DUT must ignore.
    task automatic runOp(input string name, input logic [W-1:0] v, input logic d, input logic a,
                         input logic r, input int n, input logic [W-1:0] exp);
        int busyCnt = 0;
        int doneCnt = 0;
        int doneAt  = -1;
        logic [W-1:0] outAtDone = '0;
        dataIn = v;
        load   = 1'b1;
        start  = 1'b0;
        tick();
        load  = 1'b0;
        dir   = d;
        arith = a;
        rot   = r;
        shamt = SW'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j <= n + 4; j++) begin
            if (busy) busyCnt++;
            if (done) begin
                doneCnt++;
                if (doneAt < 0) begin
                    doneAt    = j;
                    outAtDone = dataOut;
                end
            end
            dir    = 1'($urandom);
            arith  = 1'($urandom);
            rot    = 1'($urandom);
            shamt  = SW'($urandom);
            dataIn = $urandom;
            load   = (j <= n) ? 1'($urandom) : 1'b0;
            start  = (j <= n) ? 1'($urandom) : 1'b0;
            tick();
        end
        load  = 1'b0;
        start = 1'b0;
        check({name, "_busycycles"}, W'(busyCnt), W'(n));
        check({name, "_donelatency"}, W'(doneAt), W'(n + 1));
        check({name, "_donecount"}, W'(doneCnt), 32'd1);
        check({name, "_result"}, outAtDone, exp);
        check({name, "_held"}, dataOut, exp);
    endtask

    initial begin
        logic [W-1:0] v;
        logic         d, a, r;
        int           n;

        rst = 1'b1; dataIn = 32'hDEADBEEF; load = 1'b1; start = 1'b1;
        dir = 1'b0; arith = 1'b0; shamt = 5'd3; rot = 1'b0;
        tick();
        tick();
        check("reset_out", dataOut, 32'h0);
        check("reset_busy", W'(busy), 32'd0);
        check("reset_done", W'(done), 32'd0);
        rst = 1'b0; load = 1'b0; start = 1'b0;
        tick();

        vecs.push_back('{32'h000000F0, 1'b0, 1'b0, 1'b0, 4,  32'h00000F00});
        vecs.push_back('{32'h80000000, 1'b1, 1'b1, 1'b0, 3,  32'hF0000000});
        vecs.push_back('{32'h80000000, 1'b1, 1'b0, 1'b0, 3,  32'h10000000});
        vecs.push_back('{32'h12345678, 1'b0, 1'b0, 1'b0, 0,  32'h12345678});
        vecs.push_back('{32'h00000001, 1'b0, 1'b0, 1'b0, 31, 32'h80000000});
        vecs.push_back('{32'h80000000, 1'b1, 1'b1, 1'b0, 31, 32'hFFFFFFFF});
        vecs.push_back('{32'h80000000, 1'b1, 1'b0, 1'b0, 31, 32'h00000001});
        vecs.push_back('{32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 4,  32'h07FFFFFF});
        vecs.push_back('{32'h0000000F, 1'b0, 1'b1, 1'b0, 1,  32'h0000001E});
`ifdef SC_REGSHIFTER_ROTATE_EN
        vecs.push_back('{32'h00000001, 1'b1, 1'b0, 1'b1, 1,  32'h80000000});
        vecs.push_back('{32'hF0000000, 1'b0, 1'b0, 1'b1, 4,  32'h0000000F});
        vecs.push_back('{32'h80000001, 1'b1, 1'b1, 1'b1, 4,  32'h18000000});
`endif
        foreach (vecs[i]) begin
            runOp($sformatf("vec%0d", i), vecs[i].loadVal, vecs[i].dir, vecs[i].arith,
                  vecs[i].rot, vecs[i].shamt, vecs[i].expOut);
        end

        // Load beats Start in the same IDLE cycle: value captured, no shift begins.
        dataIn = 32'h000000A5; load = 1'b1; start = 1'b1; dir = 1'b0; shamt = 5'd2;
        tick();
        load = 1'b0; start = 1'b0;
        check("loadwins_out", dataOut, 32'h000000A5);
        check("loadwins_busy", W'(busy), 32'd0);
        tick();
        check("loadwins_busy2", W'(busy), 32'd0);
        check("loadwins_out2", dataOut, 32'h000000A5);

        // Load ignored while shifting, then reset mid-shift aborts.
        dataIn = 32'hFFFFFFFF; load = 1'b1;
        tick();
        load = 1'b0; dir = 1'b0; arith = 1'b0; shamt = 5'd8; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        dataIn = 32'h0; load = 1'b1;
        tick();
        load = 1'b0;
        check("midshift_loadignored", dataOut, 32'hFFFFFFFC);
        check("midshift_busy", W'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out", dataOut, 32'h0);
        check("abort_busy", W'(busy), 32'd0);
        check("abort_done", W'(done), 32'd0);
        tick();
        check("abort_nodone", W'(done), 32'd0);
        runOp("after_abort", 32'h00000003, 1'b0, 1'b0, 1'b0, 1, 32'h00000006);

        for (int i = 0; i < 40; i++) begin
            v = $urandom;
            d = 1'($urandom);
            a = 1'($urandom);
`ifdef SC_REGSHIFTER_ROTATE_EN
            r = 1'($urandom);
`else
            r = 1'b0;
`endif
            n = $urandom_range(0, 31);
            runOp($sformatf("rnd%0d", i), v, d, a, r, n, model(v, d, a, r, n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
